// File: rtl/cla_sub16_seq.sv
// Sequential subtractor: a - b - bin, one 4-bit carry-lookahead slice per cycle, LSB slice first.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module cla_sub16_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NSLICE = WIDTH / 4;
   localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int unsigned MSB    = WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [IW-1:0]    idx;
   logic             carry;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;

   logic [3:0] sa;
   logic [3:0] sb;
   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;
   logic [3:0] sum;

   // Operand slice select and two-level lookahead on a + ~b
   always_comb begin
      sa = '0;
      sb = '0;
      for (int i = 0; i < int'(NSLICE); i++) begin
         if (idx == IW'(i)) begin
            sa = a_q[i*4 +: 4];
            sb = b_q[i*4 +: 4];
         end
      end
      p    = sa ^ ~sb;
      g    = sa & ~sb;
      c[0] = carry;
      c[1] = g[0] | (p[0] & carry);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & carry);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry);
      sum  = p ^ c[3:0];
   end

   // New slice shifts in from the top; after NSLICE cycles slice 0 sits at the bottom
   assign res_next = WIDTH'({sum, res} >> 4);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         carry <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         res   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
`ifdef SUB_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  carry <= ~bin;
                  idx   <= '0;
                  state <= CALC;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            CALC: begin
               res   <= res_next;
               carry <= c[4];
               idx   <= idx + IW'(1);
               if (idx == IW'(NSLICE - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  diff  <= res_next;
                  bout  <= ~c[4];
`ifdef SUB_OVF_EN
                  ovf   <= (a_q[MSB] != b_q[MSB]) & (res_next[MSB] != a_q[MSB]);
`endif
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cla_sub16_seq.sv
// Self-checking bench for cla_sub16_seq (WIDTH=16): directed table, control corner cases, random sweep.
// Checks ovf only when SUB_OVF_EN is defined.
module tb_cla_sub16_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        busy;
   logic        done;
   logic [15:0] diff;
   logic        bout;
`ifdef SUB_OVF_EN
   logic        ovf;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cla_sub16_seq #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] diff;
      logic        bout;
      logic        ovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic get_ovf();
`ifdef SUB_OVF_EN
      return ovf;
`else
      return 1'b0;
`endif
   endfunction

   // One operation: returns edges from acceptance to done (-1 on timeout) and busy just after acceptance
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                         output int lat, output logic busy_acc);
      @(posedge clk); #1;
      a = ta; b = tb; bin = tbin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy_acc = busy;
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   vec_t vt[12];
   int          lat;
   logic        bacc;
   int          ndone;
   logic [15:0] ra, rb, ed;
   logic        rbin;
   logic [16:0] wide;

   initial begin
      vt[0]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vt[1]  = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vt[2]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
      vt[3]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
      vt[4]  = '{16'hFFFF, 16'h0F0F, 1'b0, 16'hF0F0, 1'b0, 1'b0};
      vt[5]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
      vt[6]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
      vt[7]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vt[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vt[9]  = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
      vt[10] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vt[11] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_diff", 32'(diff), 32'd0);
      check("reset_bout", 32'(bout), 32'd0);
      check("reset_ovf",  32'(get_ovf()), 32'd0);
      rst = 1'b0;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         run_op(vt[i].a, vt[i].b, vt[i].bin, lat, bacc);
         check($sformatf("v%0d_busy", i), 32'(bacc), 32'd1);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
         check($sformatf("v%0d_diff", i), 32'(diff), 32'(vt[i].diff));
         check($sformatf("v%0d_bout", i), 32'(bout), 32'(vt[i].bout));
`ifdef SUB_OVF_EN
         check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vt[i].ovf));
`endif
         @(posedge clk); #1;
         check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
         check($sformatf("v%0d_hold", i), 32'(diff), 32'(vt[i].diff));
      end

      // Start during CALC is ignored
      @(posedge clk); #1;
      a = 16'hFFFF; b = 16'h0F0F; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      a = 16'h1111; b = 16'h2222; bin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; lat = -1;
      for (int k = 3; k <= 14; k++) begin
         if (done) begin
            ndone++;
            if (lat < 0) lat = k - 1;
         end
         @(posedge clk); #1;
      end
      check("ign_ndone", 32'(ndone), 32'd1);
      check("ign_latency", 32'(lat), 32'd4);
      check("ign_diff", 32'(diff), 32'hF0F0);
      check("ign_bout", 32'(bout), 32'd0);
      check("ign_busy", 32'(busy), 32'd0);

      // Reset two cycles into CALC aborts without done
      a = 16'h1234; b = 16'h0001; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      check("rst_ovf",  32'(get_ovf()), 32'd0);
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         if (done || busy) ndone++;
         @(posedge clk); #1;
      end
      check("rst_no_done", 32'(ndone), 32'd0);
      run_op(16'h0005, 16'h0003, 1'b0, lat, bacc);
      check("post_rst_latency", 32'(lat), 32'd4);
      check("post_rst_diff", 32'(diff), 32'h0002);
      check("post_rst_bout", 32'(bout), 32'd0);

      // Back-to-back with start held: done every 5 cycles
      @(posedge clk); #1;
      a = 16'h0100; b = 16'h0001; bin = 1'b0; start = 1'b1;
      for (int op = 0; op < 3; op++) begin
         @(posedge clk); #1;
         // accepted at this edge; scramble inputs for the next op while in flight
         ra = a; rb = b; rbin = bin;
         ed = ra - rb - 16'(rbin);
         lat = -1;
         for (int k = 1; k <= 8; k++) begin
            if (k == 2) begin
               a = 16'(16'h3000 + 16'(op * 16'h0111));
               b = 16'(16'h0400 + 16'(op));
               bin = 1'(op);
            end
            @(posedge clk); #1;
            if (done) begin
               lat = k;
               break;
            end
         end
         check($sformatf("b2b%0d_latency", op), 32'(lat), 32'd4);
         check($sformatf("b2b%0d_diff", op), 32'(diff), 32'(ed));
         check($sformatf("b2b%0d_bout", op), 32'(bout), 32'({1'b0, ra} < ({1'b0, rb} + 17'(rbin))));
      end
      start = 1'b0;
      @(posedge clk); #1;
      check("b2b_idle_busy", 32'(busy), 32'd0);

      // Random sweep against a reference model
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
         if (i % 7 == 0) rb = ra;
         wide = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
         run_op(ra, rb, rbin, lat, bacc);
         if (lat != 4) check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
         check($sformatf("rnd%0d_diff", i), 32'(diff), 32'(wide[15:0]));
         check($sformatf("rnd%0d_bout", i), 32'(bout), 32'(wide[16]));
`ifdef SUB_OVF_EN
         check($sformatf("rnd%0d_ovf", i), 32'(ovf),
               32'((ra[15] != rb[15]) && (wide[15] != ra[15])));
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cla_sub16_seq.md
CLA_SUB16_SEQ -- requirements
Module: cla_sub16_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, operand width in bits; it SHALL be a multiple of 4 and at least 4.
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port `start`, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port `a`, input, WIDTH bits: minuend, unsigned or two's complement.
REQ-006 The block SHALL have port `b`, input, WIDTH bits: subtrahend.
REQ-007 The block SHALL have port `bin`, input, 1 bit: borrow-in.
REQ-008 The block SHALL have port `busy`, output, 1 bit: high while a subtraction is in progress.
REQ-009 The block SHALL have port `done`, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port `diff`, output, WIDTH bits: result a - b - bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port `bout`, output, 1 bit: borrow-out, high when unsigned a < b + bin.
REQ-012 The block SHALL have port `ovf`, output, 1 bit: signed overflow; present only when SUB_OVF_EN is defined (see REQ-030).

Function
REQ-013 The block SHALL compute one 4-bit slice per cycle, least-significant slice first, using 4-bit carry-lookahead logic on a + ~b with slice carry-in = ~bin for slice 0.
- Each slice SHALL generate p_i = a_i ^ ~b_i and g_i = a_i & ~b_i.
- All four internal carries and the slice carry-out SHALL come from two-level lookahead equations, not from a ripple chain.
REQ-014 The carry-out of each slice SHALL be registered and SHALL feed the next slice in the following cycle.
REQ-015 The final borrow SHALL be bout = ~carry-out of the last slice.
REQ-016 The state machine SHALL have three states: IDLE, CALC, DONE.
REQ-017 `start` SHALL be accepted only in IDLE or DONE.
- On acceptance, `a`, `b` and `bin` SHALL be latched, the slice index SHALL be cleared to 0, and the next state SHALL be CALC.
REQ-018 In CALC, each cycle SHALL compute the indexed slice into an internal result register and increment the index.
- After slice WIDTH/4-1 the next state SHALL be DONE.
REQ-019 Latency: `start` sampled at edge N SHALL produce `done` = 1 in the cycle after edge N+WIDTH/4 (edge N+4 for WIDTH=16).
REQ-020 In DONE, `done` SHALL be 1 for exactly one cycle.
- `diff`, `bout` (and `ovf`) SHALL update at the same edge that enters DONE.
- The next state SHALL be IDLE, or CALC if `start` is high.
REQ-021 `busy` SHALL be 1 exactly while in CALC.
REQ-022 `start` asserted in CALC SHALL be ignored: no relatch and no restart.
REQ-023 `diff`/`bout`/`ovf` SHALL hold their last result until the next completion.
- Changes on `a`, `b` or `bin` after acceptance SHALL NOT affect the operation in flight.
REQ-024 Back-to-back operation SHALL be supported: `start` held high gives one result every WIDTH/4+1 cycles.

Reset
REQ-025 When `rst` = 1 at a rising edge, the block SHALL enter IDLE and clear the slice index, internal carry and internal result.
REQ-026 The reset values SHALL be: `busy` = 0, `done` = 0, `diff` = 0, `bout` = 0, `ovf` = 0.
REQ-027 `rst` SHALL take priority over `start`.
- A reset mid-CALC SHALL abort the operation without asserting `done`.
REQ-028 The first `start` after reset release SHALL be accepted normally.

Configuration
REQ-029 The block SHALL support the macro SUB_OVF_EN.
REQ-030 With SUB_OVF_EN defined, the `ovf` port and logic SHALL be present.
- `ovf` = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
- `ovf` SHALL use the latched operands and update together with `diff`.
REQ-031 Without SUB_OVF_EN, the `ovf` port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-032 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0; `done` in the 5th cycle after `start`.
REQ-033 a=0x1234, b=0x1234, bin=1 -> diff=0xFFFF, bout=1; and a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0.
REQ-034 a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1 (SUB_OVF_EN defined); same stimulus without the macro -> ovf port absent, diff/bout identical.
REQ-035 `start` with a=0xFFFF, b=0x0F0F; pulse `start` again with different operands during CALC -> single `done`, diff=0xF0F0, bout=0, second request ignored.
REQ-036 `rst` asserted 2 cycles after `start` -> `busy`=0 and `done` never pulses; all outputs 0; next `start` (a=5, b=3) -> diff=0x0002.
REQ-037 `start` held high for 3 operations -> `done` every 5 cycles; each result matches a - b - bin for its own latched operands; random 1000-vector comparison against a reference model.
